uart_rx: RTL and testbench

//   Serial-to-parallel UART receiver, the counterpart of uart_tx, sharing its 16x oversampling tick s_tck.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    STOP   = 3'b011,
    PARITY = 3'b100
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line.
// Resets to 1 (line idle) so that releasing reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start qualification, mid-bit sampling, stop check.
// Optional parity stage is enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int SB_tck = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PAR_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tck,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tck,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int SHIFT = 8 - DBIT;

  logic        rx_s;
  uart_state_e state_q, state_d;
  logic [3:0]  s_q, s_d;
  logic [2:0]  n_q, n_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  dout_q, dout_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic [7:0]  data_aligned;

  uart_rx_sync u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  // Data arrives LSB first into the top of b, so right-align for DBIT < 8.
  assign data_aligned = b_q >> SHIFT;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tck) begin
          if (s_q == 4'(MID_TICK)) begin
            // Still low at mid start bit: real start, otherwise a glitch.
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tck) begin
          if (s_q == 4'(OVERSAMPLE - 1)) begin
            s_d = '0;
            b_d = {rx_s, b_q[7:1]};
            if (n_q == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tck) begin
          if (s_q == 4'(OVERSAMPLE - 1)) begin
            s_d     = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tck) begin
          if (s_q == 4'(SB_tck - 1)) begin
            state_d = IDLE;
            if (rx_s) begin
              dout_d = data_aligned;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            perr_d = par_q ^ (^data_aligned) ^ PAR_ODD;
`endif
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout        = dout_q;
  assign rx_done_tck = done_q;
  assign frame_err   = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a DBIT=8 and a DBIT=7 receiver driven by a behavioural serial transmitter.
// Expected events come from a frame-level model; observed pulses are queued by a monitor.
`timescale 1ns/1ps
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tck = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx7 = 1'b1;
  logic [7:0] dout8, dout7;
  logic       done8, ferr8, perr8, done7, ferr7, perr7;

  always #5 clk = ~clk;

  // One s_tck pulse every 4 clocks, changed away from the active edge.
  int tdiv = 0;
  always @(negedge clk) begin
    tdiv  = (tdiv == 3) ? 0 : tdiv + 1;
    s_tck = (tdiv == 0);
  end

  uart_rx #(.DBIT(8), .SB_tck(16)) dut8 (
    .clk(clk), .reset_n(reset_n), .s_tck(s_tck), .rx(rx8),
    .dout(dout8), .rx_done_tck(done8), .frame_err(ferr8), .parity_err(perr8)
  );

  uart_rx #(.DBIT(7), .SB_tck(16)) dut7 (
    .clk(clk), .reset_n(reset_n), .s_tck(s_tck), .rx(rx7),
    .dout(dout7), .rx_done_tck(done7), .frame_err(ferr7), .parity_err(perr7)
  );

  typedef struct packed {
    logic       done;
    logic       ferr;
    logic       perr;
    logic [7:0] dout;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    ev_t        exp;
  } vec_t;

  ev_t q8[$];
  ev_t q7[$];

  // Every cycle with any pulse high becomes one event; a 2-cycle pulse shows as an extra event.
  always @(negedge clk) begin
    if (done8 || ferr8 || perr8) q8.push_back({done8, ferr8, perr8, dout8});
    if (done7 || ferr7 || perr7) q7.push_back({done7, ferr7, perr7, dout7});
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] last8 = 8'h00;
  logic [7:0] last7 = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (s_tck) c++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit sel7, input logic v);
    if (sel7) rx7 = v;
    else      rx8 = v;
  endtask

  function automatic logic [7:0] mask_of(input bit sel7);
    return sel7 ? 8'h7F : 8'hFF;
  endfunction

  // A bad stop bit is low only long enough to be sampled, so the tail is not mistaken for a new start.
  task automatic send_frame(input bit sel7, input logic [7:0] data, input bit stop_ok, input bit par_flip);
    int nb = sel7 ? 7 : 8;
    drive(sel7, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < nb; i++) begin
      drive(sel7, data[i]);
      wait_ticks(16);
    end
    if (PAR_ON) begin
      drive(sel7, (^(data & mask_of(sel7))) ^ par_flip);
      wait_ticks(16);
    end
    if (stop_ok) begin
      drive(sel7, 1'b1);
      wait_ticks(16);
    end else begin
      drive(sel7, 1'b0);
      wait_ticks(10);
      drive(sel7, 1'b1);
      wait_ticks(6);
    end
  endtask

  function automatic ev_t model(input bit sel7, input logic [7:0] data, input bit stop_ok,
                                input bit par_flip, input logic [7:0] last);
    ev_t e;
    e.done = stop_ok;
    e.ferr = !stop_ok;
    e.perr = PAR_ON & par_flip;
    e.dout = stop_ok ? (data & mask_of(sel7)) : last;
    return e;
  endfunction

  task automatic expect_ev(input bit sel7, input string name, input ev_t exp);
    int   budget = 0;
    ev_t  got;
    while ((sel7 ? q7.size() : q8.size()) == 0 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if ((sel7 ? q7.size() : q8.size()) == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no pulse within budget, expected event %0h", name, exp);
    end else begin
      got = sel7 ? q7.pop_front() : q8.pop_front();
      chk({name, " done"}, 32'(got.done), 32'(exp.done));
      chk({name, " frame_err"}, 32'(got.ferr), 32'(exp.ferr));
      chk({name, " parity_err"}, 32'(got.perr), 32'(exp.perr));
      chk({name, " dout"}, 32'(got.dout), 32'(exp.dout));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    logic [7:0] abort_byte;
    ev_t e;
    logic [7:0] d;
    bit ok, pf;

    tbl[0] = '{8'h55, 1'b1, '{1'b1, 1'b0, 1'b0, 8'h55}};
    tbl[1] = '{8'hA3, 1'b0, '{1'b0, 1'b1, 1'b0, 8'h55}};
    tbl[2] = '{8'h00, 1'b1, '{1'b1, 1'b0, 1'b0, 8'h00}};
    tbl[3] = '{8'hFF, 1'b1, '{1'b1, 1'b0, 1'b0, 8'hFF}};
    tbl[4] = '{8'h3C, 1'b1, '{1'b1, 1'b0, 1'b0, 8'h3C}};

    // Reset state
    repeat (5) @(negedge clk);
    chk("reset dout8", 32'(dout8), 32'h0);
    chk("reset done8", 32'(done8), 32'h0);
    chk("reset ferr8", 32'(ferr8), 32'h0);
    chk("reset perr8", 32'(perr8), 32'h0);
    chk("reset dout7", 32'(dout7), 32'h0);
    reset_n = 1'b1;
    wait_ticks(4);

    // Directed table, frames back to back
    for (int i = 0; i < 5; i++) begin
      send_frame(1'b0, tbl[i].data, tbl[i].stop_ok, 1'b0);
      expect_ev(1'b0, $sformatf("vec%0d", i), tbl[i].exp);
      $display("vec%0d data=%02h stop_ok=%0d dout8=%02h", i, tbl[i].data, tbl[i].stop_ok, dout8);
      last8 = tbl[i].exp.dout;
    end

    // Short low glitch in IDLE must be rejected
    wait_ticks(20);
    rx8 = 1'b0;
    wait_ticks(5);
    rx8 = 1'b1;
    wait_ticks(30);
    chk("glitch no pulse", 32'(q8.size()), 32'h0);
    chk("glitch dout", 32'(dout8), 32'(last8));
    $display("glitch dout8=%02h", dout8);

    // DBIT=7 frame
    send_frame(1'b1, 8'h5A, 1'b1, 1'b0);
    expect_ev(1'b1, "dbit7 5A", model(1'b1, 8'h5A, 1'b1, 1'b0, last7));
    last7 = 8'h5A;
    $display("dbit7 data=5a dout7=%02h", dout7);

    // Reset in the middle of data bit 4
    abort_byte = 8'hC6;
    rx8 = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx8 = abort_byte[i];
      wait_ticks(16);
    end
    rx8 = abort_byte[4];
    wait_ticks(8);
    reset_n = 1'b0;
    rx8 = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset dout8", 32'(dout8), 32'h0);
    chk("midreset done8", 32'(done8), 32'h0);
    chk("midreset ferr8", 32'(ferr8), 32'h0);
    chk("midreset dout7", 32'(dout7), 32'h0);
    reset_n = 1'b1;
    last8 = 8'h00;
    last7 = 8'h00;
    wait_ticks(20);
    chk("midreset no pulse", 32'(q8.size()), 32'h0);
    $display("midreset dout8=%02h", dout8);

    send_frame(1'b0, 8'h81, 1'b1, 1'b0);
    expect_ev(1'b0, "post-reset 81", model(1'b0, 8'h81, 1'b1, 1'b0, last8));
    last8 = 8'h81;
    $display("post-reset data=81 dout8=%02h", dout8);
    send_frame(1'b0, 8'h81, 1'b1, 1'b1);
    expect_ev(1'b0, "flip-parity 81", model(1'b0, 8'h81, 1'b1, 1'b1, last8));
    $display("flip-parity data=81 dout8=%02h perr8_expected=%0d", dout8, PAR_ON);

    // Randomised frames on both receivers
    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      pf = ($urandom_range(0, 3) == 0);
      wait_ticks($urandom_range(0, 3));
      e = model(1'b0, d, ok, pf, last8);
      send_frame(1'b0, d, ok, pf);
      expect_ev(1'b0, $sformatf("rand8 %0d", i), e);
      last8 = e.dout;
      $display("rand8 %0d data=%02h stop_ok=%0d par_flip=%0d dout8=%02h", i, d, ok, pf, dout8);
    end
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      pf = ($urandom_range(0, 3) == 0);
      e = model(1'b1, d, ok, pf, last7);
      send_frame(1'b1, d, ok, pf);
      expect_ev(1'b1, $sformatf("rand7 %0d", i), e);
      last7 = e.dout;
      $display("rand7 %0d data=%02h stop_ok=%0d par_flip=%0d dout7=%02h", i, d, ok, pf, dout7);
    end

    wait_ticks(40);
    chk("no stray events 8", 32'(q8.size()), 32'h0);
    chk("no stray events 7", 32'(q7.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
